// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter and the core control logic:
// RV32I load/store modes, FSM state codes and the bus owner.
package dmem_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  // Illegal mode, unsigned store, or misaligned half/word.
  function automatic logic access_fault(input logic we, input logic [2:0] mode,
                                        input logic [1:0] ofs);
    logic bad;
    case (mode)
      MODE_B:  bad = 1'b0;
      MODE_H:  bad = ofs[0];
      MODE_W:  bad = (ofs != 2'b00);
      MODE_BU: bad = we;
      MODE_HU: bad = we | ofs[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatting: store lane enables / replication and
// load byte/half selection with sign or zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign shifted = word >> {ofs, 3'b000};
  assign byte_s  = $signed(shifted[7:0]);
  assign half_s  = $signed(shifted[15:0]);

  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    rdata     = '0;
    case (mode)
      MODE_B: begin
        be        = 4'b0001 << ofs;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = 32'(byte_s);
      end
      MODE_BU: begin
        be        = 4'b0001 << ofs;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'd0, shifted[7:0]};
      end
      MODE_H: begin
        be        = 4'b0011 << ofs;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = 32'(half_s);
      end
      MODE_HU: begin
        be        = 4'b0011 << ofs;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {16'd0, shifted[15:0]};
      end
      MODE_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata     = word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with round-robin grant, access checks,
// BUSY timeout and lane formatting. One access in flight at a time.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_mode,
  input  logic [31:0] a_adrs,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_ack,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [2:0]  b_mode,
  input  logic [31:0] b_adrs,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_ack,
  output logic        b_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_adrs,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);

  state_t      state;
  owner_t      owner, ptr, gnt;
  logic [15:0] cnt;
  logic        err_l;
  logic        we_l, sel_we, req_any, busy, resp;
  logic [2:0]  mode_l, sel_mode;
  logic [31:0] adrs_l, wdata_l, rdata_l, sel_adrs, sel_wdata;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;

  assign req_any   = a_req | b_req;
  assign gnt       = (a_req && b_req) ? ptr : (a_req ? OWN_A : OWN_B);
  assign sel_we    = (gnt == OWN_A) ? a_we    : b_we;
  assign sel_mode  = (gnt == OWN_A) ? a_mode  : b_mode;
  assign sel_adrs  = (gnt == OWN_A) ? a_adrs  : b_adrs;
  assign sel_wdata = (gnt == OWN_A) ? a_wdata : b_wdata;

  dmem_lane_fmt u_fmt (
    .mode      (mode_l),
    .ofs       (adrs_l[1:0]),
    .wdata     (wdata_l),
    .word      (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata     (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= OWN_A;
      owner <= OWN_A;
      cnt   <= '0;
      err_l <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_any) begin
          owner <= gnt;
          ptr   <= (gnt == OWN_A) ? OWN_B : OWN_A;
          cnt   <= '0;
          if (access_fault(sel_we, sel_mode, sel_adrs[1:0])) begin
            state <= ST_RESP;
            err_l <= 1'b1;
          end else begin
            state <= ST_BUSY;
            err_l <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            state <= ST_RESP;
          end else if (cnt == TO_M1) begin
            state <= ST_RESP;
            err_l <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request fields are frozen at grant; read data is zero for stores and timeouts.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_any) begin
      we_l    <= sel_we;
      mode_l  <= sel_mode;
      adrs_l  <= sel_adrs;
      wdata_l <= sel_wdata;
      rdata_l <= '0;
    end else if (state == ST_BUSY) begin
      rdata_l <= (mem_ready && !we_l) ? rdata_ext : '0;
    end
  end

  assign busy = (state == ST_BUSY) && !reset;
  assign resp = (state == ST_RESP) && !reset;

  assign mem_req   = busy;
  assign mem_we    = busy & we_l;
  assign mem_be    = busy ? be : 4'b0000;
  assign mem_adrs  = busy ? {adrs_l[31:2], 2'b00} : '0;
  assign mem_wdata = busy ? wdata_rep : '0;

  assign a_ack   = resp && (owner == OWN_A);
  assign b_ack   = resp && (owner == OWN_B);
  assign a_err   = a_ack & err_l;
  assign b_err   = b_ack & err_l;
  assign a_rdata = a_ack ? rdata_l : '0;
  assign b_rdata = b_ack ? rdata_l : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus randomized
// accesses checked against an arithmetic reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_mode, b_mode;
  logic [31:0] a_adrs, a_wdata, b_adrs, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic        mem_req, mem_we, mem_ready;
  logic [3:0]  mem_be;
  logic [31:0] mem_adrs, mem_wdata, mem_rdata;

  int compared   = 0;
  int mismatched = 0;
  bit ptr_b;

  always #5 clk = ~clk;

  dmem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_mode(a_mode), .a_adrs(a_adrs), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_mode(b_mode), .b_adrs(b_adrs), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_adrs(mem_adrs),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] mode,
                                     input logic [31:0] adrs);
    logic legal;
    legal = (mode == 0) || (mode == 1) || (mode == 2) || (!we && (mode == 4 || mode == 5));
    return !legal || (mode % 4 == 1 && adrs % 2 != 0) || (mode % 4 == 2 && adrs % 4 != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] mode, input logic [31:0] adrs);
    int sh;
    sh = int'(adrs % 4);
    if (mode % 4 == 0) return 4'(1 << sh);
    if (mode % 4 == 1) return 4'(3 << sh);
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] mode, input logic [31:0] w);
    if (mode % 4 == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (mode % 4 == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] mode, input logic [31:0] adrs,
                                              input logic [31:0] mem);
    int bits;
    logic [31:0] v;
    if (mode % 4 == 2) return mem;
    bits = (mode % 4 == 0) ? 8 : 16;
    v = (mem >> (8 * (adrs % 4))) & ((32'd1 << bits) - 32'd1);
    if (mode < 4 && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  // One access from one side; delay = BUSY cycles without mem_ready before it rises.
  task automatic do_access(input bit side, input logic we, input logic [2:0] mode,
                           input logic [31:0] adrs, input logic [31:0] wdata,
                           input logic [31:0] mem, input int delay,
                           output logic [31:0] got);
    logic e, tmo, ackv, errv, other;
    logic [31:0] rdv;
    int busy, cyc, exp_cyc, exp_busy;
    bit done;
    e        = model_err(we, mode, adrs);
    tmo      = !e && delay >= 4;
    exp_cyc  = e ? 1 : (tmo ? 5 : delay + 2);
    exp_busy = e ? 0 : (tmo ? 4 : delay + 1);
    @(negedge clk);
    if (!side) begin
      a_req = 1'b1; a_we = we; a_mode = mode; a_adrs = adrs; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_mode = mode; b_adrs = adrs; b_wdata = wdata;
    end
    mem_rdata = mem;
    busy = 0; cyc = 0; done = 0; got = '0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ackv  = side ? b_ack : a_ack;
      errv  = side ? b_err : a_err;
      rdv   = side ? b_rdata : a_rdata;
      other = side ? a_ack : b_ack;
      if (mem_req) begin
        if (busy == 0) begin
          check("mem_we", {31'd0, mem_we}, {31'd0, we});
          check("mem_be", {28'd0, mem_be}, {28'd0, model_be(mode, adrs)});
          check("mem_adrs", mem_adrs, adrs & 32'hFFFF_FFFC);
          check("mem_wdata", mem_wdata, model_wdata(mode, wdata));
        end
        busy++;
        mem_ready = (busy == delay + 1);
      end else begin
        mem_ready = 1'b0;
      end
      if (ackv) begin
        done = 1;
        got  = rdv;
        check("ack_cycle", cyc, exp_cyc);
        check("busy_cycles", busy, exp_busy);
        check("err", {31'd0, errv}, {31'd0, e | tmo});
        check("rdata", rdv, (e || tmo || we) ? 32'd0 : model_rdata(mode, adrs, mem));
        check("other_ack", {31'd0, other}, 32'd0);
        check("idle_mem", {mem_adrs[31:6], mem_req, mem_we, mem_be}, 32'd0);
        check("idle_wdata", mem_wdata, 32'd0);
        if (!side) a_req = 1'b0; else b_req = 1'b0;
        mem_ready = 1'b0;
        ptr_b = !side;
      end
      // Requester fields may wander after grant without affecting the access.
      if (!done) begin
        if (!side) begin
          a_we = 1'($urandom); a_mode = 3'($urandom); a_adrs = $urandom; a_wdata = $urandom;
        end else begin
          b_we = 1'($urandom); b_mode = 3'($urandom); b_adrs = $urandom; b_wdata = $urandom;
        end
      end
    end
    check("ack_seen", {31'd0, done}, 32'd1);
  endtask

  // Both sides request word loads and stay high for three completions.
  task automatic rr_test();
    bit exp_b;
    int n;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_mode = 3'b010; a_adrs = 32'h10;
    b_req = 1'b1; b_we = 1'b0; b_mode = 3'b010; b_adrs = 32'h20;
    mem_rdata = 32'h1234_5678;
    exp_b = ptr_b;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      mem_ready = mem_req;
      if (a_ack || b_ack) begin
        check("rr_owner", {31'd0, b_ack}, {31'd0, exp_b});
        check("rr_single", {31'd0, a_ack & b_ack}, 32'd0);
        exp_b = !exp_b;
        n++;
        if (n == 3) begin
          a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0;
        end
      end
    end
    check("rr_count", n, 3);
    ptr_b = exp_b;
    a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic        we;
    logic [2:0]  mode;
    int          delay;
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_mode = 3'b010; a_adrs = 32'hFFFF_FFFF; a_wdata = 32'hFFFF_FFFF;
    b_req = 1'b1; b_we = 1'b1; b_mode = 3'b010; b_adrs = 32'hFFFF_FFFF; b_wdata = 32'hFFFF_FFFF;
    mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
    ptr_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {26'd0, mem_req, mem_we, a_ack, a_err, b_ack, b_err}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_adrs", mem_adrs, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    rr_test();

    do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1, got);
    do_access(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, got);
    check("lb_const", got, 32'hFFFF_FF80);
    do_access(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, got);
    check("lbu_const", got, 32'h0000_0080);
    do_access(1'b0, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, got);
    do_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 99, got);
    check("timeout_rdata", got, 32'd0);
    do_access(1'b1, 1'b1, 3'b101, 32'h202, 32'h1234, 32'h0, 0, got);
    do_access(1'b1, 1'b1, 3'b000, 32'h302, 32'h0000_00A5, 32'h0, 2, got);
    do_access(1'b0, 1'b0, 3'b101, 32'h306, 32'h0, 32'h8001_7FFF, 0, got);

    for (int i = 0; i < 40; i++) begin
      we    = 1'($urandom);
      mode  = ($urandom % 4 == 0) ? 3'($urandom) : ((we) ? 3'($urandom % 3) : 3'($urandom % 3 + (($urandom % 2) * 4)));
      delay = ($urandom % 8 == 0) ? 9 : int'($urandom % 3);
      do_access(1'($urandom), we, mode, $urandom, $urandom, $urandom, delay, got);
    end

    rr_test();

    // Reset while BUSY abandons the access.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_mode = 3'b010; a_adrs = 32'h40;
    mem_ready = 1'b0;
    @(negedge clk);
    check("busy_before_reset", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_gate", {30'd0, mem_req, a_ack}, 32'd0);
    @(negedge clk);
    check("reset_busy_next", {29'd0, mem_req, a_ack, b_ack}, 32'd0);
    reset = 1'b0;
    a_req = 1'b0;
    ptr_b = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {29'd0, mem_req, a_ack, b_ack}, 32'd0);
    @(negedge clk);
    check("post_reset_idle2", {29'd0, mem_req, a_ack, b_ack}, 32'd0);

    rr_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
